// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone block copy / fill engine.
package wb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } dma_mode_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_dma_copy.sv
// Wishbone classic initiator: copies a block of words (read then write per
// word) or fills a block with a constant. Ack-driven, with an optional
// per-access timeout that aborts the transfer and raises a sticky error.
module wb_dma_copy
  import wb_dma_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LW      = AW + 1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [AW-1:0] src_adr_i,
  input  logic [AW-1:0] dst_adr_i,
  input  logic [LW-1:0] len_i,
  input  logic [31:0]   fill_dat_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  input  logic          wb_ack_i,
  input  logic [31:0]   wb_dat_i
);

  // Timeout counter only needs to reach TIMEOUT-1; keep at least one bit.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [AW-1:0] ADR_ONE = AW'(1);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);

  dma_state_e    state_r;
  dma_mode_e     mode_r;
  logic [AW-1:0] src_ptr_r;
  logic [AW-1:0] dst_ptr_r;
  logic [LW-1:0] cnt_r;
  logic [31:0]   fill_r;
  logic [31:0]   data_buf_r;
  logic [TW-1:0] to_cnt_r;
  logic          wr_next_r;   // copy only: the access after GAP is the write
  logic          timeout_hit_s;

  // The access in flight has waited its last allowed cycle without an ack.
  assign timeout_hit_s = (TIMEOUT != 0) && (to_cnt_r == TO_LAST);

  // Transfer FSM; every bus and status output is registered here.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_r    <= ST_IDLE;
      mode_r     <= COPY;
      src_ptr_r  <= '0;
      dst_ptr_r  <= '0;
      cnt_r      <= '0;
      fill_r     <= 32'h0000_0000;
      data_buf_r <= 32'h0000_0000;
      to_cnt_r   <= '0;
      wr_next_r  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= 4'h0;
      wb_adr_o   <= '0;
      wb_dat_o   <= 32'h0000_0000;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              // Empty transfer: report completion without touching the bus.
              state_r <= ST_DONE;
              done_o  <= 1'b1;
            end else begin
              mode_r    <= dma_mode_e'(mode_i);
              src_ptr_r <= src_adr_i;
              dst_ptr_r <= dst_adr_i;
              cnt_r     <= len_i;
              fill_r    <= fill_dat_i;
              to_cnt_r  <= '0;
              wr_next_r <= 1'b0;
              err_o     <= 1'b0;
              busy_o    <= 1'b1;
              wb_cyc_o  <= 1'b1;
              wb_stb_o  <= 1'b1;
              wb_sel_o  <= SEL_ALL;
              if (mode_i == FILL) begin
                state_r  <= ST_WRITE;
                wb_we_o  <= 1'b1;
                wb_adr_o <= dst_adr_i;
                wb_dat_o <= fill_dat_i;
              end else begin
                state_r  <= ST_READ;
                wb_we_o  <= 1'b0;
                wb_adr_o <= src_adr_i;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_READ: begin
          if (wb_ack_i) begin
            data_buf_r <= wb_dat_i;
            src_ptr_r  <= src_ptr_r + ADR_ONE;
            wr_next_r  <= 1'b1;
            wb_stb_o   <= 1'b0;
            wb_sel_o   <= 4'h0;
            state_r    <= ST_GAP;
          end else if (timeout_hit_s) begin
            err_o    <= 1'b1;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            state_r  <= ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end

        ST_WRITE: begin
          if (wb_ack_i) begin
            dst_ptr_r <= dst_ptr_r + ADR_ONE;
            cnt_r     <= cnt_r - LEN_ONE;
            wr_next_r <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_sel_o  <= 4'h0;
            if (cnt_r == LEN_ONE) begin
              done_o   <= 1'b1;
              busy_o   <= 1'b0;
              wb_cyc_o <= 1'b0;
              wb_we_o  <= 1'b0;
              state_r  <= ST_DONE;
            end else begin
              state_r <= ST_GAP;
            end
          end else if (timeout_hit_s) begin
            err_o    <= 1'b1;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            state_r  <= ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end

        ST_GAP: begin
          // Strobe was low for one cycle so a registered-ack responder
          // cannot re-ack; now launch the next access.
          to_cnt_r <= '0;
          wb_stb_o <= 1'b1;
          wb_sel_o <= SEL_ALL;
          if (mode_r == FILL) begin
            state_r  <= ST_WRITE;
            wb_we_o  <= 1'b1;
            wb_adr_o <= dst_ptr_r;
            wb_dat_o <= fill_r;
          end else if (wr_next_r) begin
            state_r  <= ST_WRITE;
            wb_we_o  <= 1'b1;
            wb_adr_o <= dst_ptr_r;
            wb_dat_o <= data_buf_r;
          end else begin
            state_r  <= ST_READ;
            wb_we_o  <= 1'b0;
            wb_adr_o <= src_ptr_r;
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
        end

        default: begin
          state_r  <= ST_IDLE;
          busy_o   <= 1'b0;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_sel_o <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Self-checking bench for wb_dma_copy: directed vector table, two hand-written
// corner sequences (mid-transfer start, mid-transfer reset) and randomized
// transfers against a memory-level reference model.
module tb_wb_dma_copy;

  localparam int AW  = 10;
  localparam int LW  = 11;
  localparam int TMO = 8;
  localparam int DEPTH = 1024;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic [31:0]   fill;
  logic          busy, done, err;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [31:0]   dat_o;
  logic          ack;
  logic [31:0]   dat_i;

  wb_dma_copy #(.AW(AW), .LW(LW), .TIMEOUT(TMO)) dut (
    .clk_i      (clk),
    .rst_in     (rst_n),
    .start_i    (start),
    .mode_i     (mode),
    .src_adr_i  (src),
    .dst_adr_i  (dst),
    .len_i      (len),
    .fill_dat_i (fill),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .wb_cyc_o   (cyc),
    .wb_stb_o   (stb),
    .wb_we_o    (we),
    .wb_sel_o   (sel),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat_o),
    .wb_ack_i   (ack),
    .wb_dat_i   (dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- responder: registered ack, optional wait states -------
  logic [31:0]   mem [0:DEPTH-1];
  logic [31:0]   ref_mem [0:DEPTH-1];
  logic          ack_en;
  int            delay_max;
  int            wait_cnt;
  logic          bd_we, bd_rand;
  logic [AW-1:0] bd_adr;
  logic [31:0]   bd_dat;

  always @(posedge clk) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      dat_i    <= 32'h0;
      wait_cnt <= 0;
    end else begin
      if (bd_rand) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
      end else if (bd_we) begin
        mem[bd_adr] <= bd_dat;
      end
      if (cyc && stb && !ack && ack_en) begin
        if (wait_cnt == 0) begin
          ack   <= 1'b1;
          dat_i <= mem[adr];
          if (we) mem[adr] <= dat_o;
          wait_cnt <= $urandom_range(delay_max, 0);
        end else begin
          ack      <= 1'b0;
          wait_cnt <= wait_cnt - 1;
        end
      end else begin
        ack <= 1'b0;
        if (!cyc) wait_cnt <= 0;
      end
    end
  end

  // ---------------- scoring ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_adr = a; bd_dat = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
  endtask

  // Reference: word i of the block is read then written, in address order.
  task automatic apply_model(input logic m, input int s, input int d, input int n, input logic [31:0] f);
    for (int i = 0; i < n; i++) begin
      if (m) ref_mem[(d + i) % DEPTH] = f;
      else   ref_mem[(d + i) % DEPTH] = ref_mem[(s + i) % DEPTH];
    end
  endtask

  function automatic int mem_mismatches();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  // ---------------- transfer driver ----------------
  int   r_edge, r_stb, r_cyc;
  logic r_seen, r_busy0, r_busy_done;

  task automatic xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic [LW-1:0] n, input logic [31:0] f,
                      input int poke, input int budget);
    start = 1'b1; mode = m; src = s; dst = d; len = n; fill = f;
    @(posedge clk); #1;          // edge 0: start sampled
    start = 1'b0;
    r_edge = -1; r_stb = 0; r_cyc = 0; r_seen = 1'b0; r_busy_done = 1'b1;
    r_busy0 = busy;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      start = 1'b0;
      if (stb) r_stb++;
      if (cyc) r_cyc++;
      if (done) begin
        r_seen = 1'b1; r_edge = k; r_busy_done = busy;
        break;
      end
      if (k == poke) begin
        start = 1'b1; mode = ~m; src = s ^ 10'h155; dst = d ^ 10'h2AA;
        len = 11'd7; fill = ~f;
      end
    end
    start = 1'b0;
    if (!r_seen) $display("FAIL timeout: done_o not seen within %0d cycles", budget);
    @(posedge clk); #1;          // DONE cycle ends
  endtask

  task automatic run_checks(input string tag, input int exp_edge, input logic exp_err,
                            input int exp_stb, input logic exp_busy0);
    check({tag, " done_seen"}, r_seen, 1'b1);
    if (exp_edge >= 0) check({tag, " done_edge"}, r_edge, exp_edge);
    check({tag, " err"}, err, exp_err);
    if (exp_stb >= 0) check({tag, " stb_cycles"}, r_stb, exp_stb);
    check({tag, " busy_after_start"}, r_busy0, exp_busy0);
    check({tag, " busy_in_done"}, r_busy_done, 1'b0);
    check({tag, " mem"}, mem_mismatches(), 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string         name;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [31:0]   fill;
    logic          ack_en;
    int            poke;
    int            exp_edge;
    logic          exp_err;
    int            exp_stb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"copy3",     1'b0, 10'h010, 10'h200, 11'd3, 32'h0,         1'b1, -1, 17, 1'b0, 12};
    vecs[1] = '{"fill_wrap", 1'b1, 10'h000, 10'h3FE, 11'd4, 32'hDEADBEEF,  1'b1, -1, 11, 1'b0, 8};
    vecs[2] = '{"len0",      1'b0, 10'h010, 10'h100, 11'd0, 32'h0,         1'b1, -1, 0,  1'b0, 0};
    vecs[3] = '{"timeout",   1'b0, 10'h010, 10'h100, 11'd3, 32'h0,         1'b0, -1, 8,  1'b1, 8};
    vecs[4] = '{"len0_keep", 1'b1, 10'h000, 10'h100, 11'd0, 32'h1,         1'b1, -1, 0,  1'b1, 0};
    vecs[5] = '{"fill1_clr", 1'b1, 10'h000, 10'h150, 11'd1, 32'h12345678,  1'b1, -1, 2,  1'b0, 2};
    vecs[6] = '{"copy_wrap", 1'b0, 10'h3FF, 10'h120, 11'd2, 32'h0,         1'b1, -1, 11, 1'b0, 8};
    vecs[7] = '{"poke",      1'b0, 10'h020, 10'h280, 11'd3, 32'h0,         1'b1, 5,  17, 1'b0, 12};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] old_w;
    int          done_cnt, cyc_cnt;
    logic        m;
    logic [AW-1:0] s, d;
    int          n, ee, es;
    logic [31:0] f;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = 32'h0;
    ack_en = 1'b1; delay_max = 0; bd_we = 1'b0; bd_rand = 1'b0; bd_adr = '0; bd_dat = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, err, cyc, stb, we, sel, adr, dat_o}, 64'h0);
    rst_n = 1'b1;

    bd_rand = 1'b1; @(posedge clk); #1; bd_rand = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bd_write(10'h010 + 10'(i), 32'hA5A50001 + 32'(i));
      bd_write(10'h020 + 10'(i), 32'h5A5A0010 + 32'(i));
    end

    foreach (vecs[i]) begin
      ack_en = vecs[i].ack_en;
      snapshot();
      xfer(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill, vecs[i].poke, 200);
      if (!vecs[i].exp_err)
        apply_model(vecs[i].mode, int'(vecs[i].src), int'(vecs[i].dst), int'(vecs[i].len), vecs[i].fill);
      run_checks(vecs[i].name, vecs[i].exp_edge, vecs[i].exp_err, vecs[i].exp_stb,
                 vecs[i].len != 11'd0);
      if (vecs[i].len == 11'd0) check({vecs[i].name, " cyc_cycles"}, r_cyc, 0);
      ack_en = 1'b1;
    end
    check("copy3 word0", mem[10'h200], 32'hA5A50001);
    check("fill wrap word_000", mem[10'h000], 32'hDEADBEEF);

    // Reset in the middle of the second write of a three-word copy.
    for (int i = 0; i < 3; i++) begin
      bd_write(10'h030 + 10'(i), 32'h11110001 + 32'(i));
      bd_write(10'h2C0 + 10'(i), 32'h0BAD0000 + 32'(i));
    end
    old_w = mem[10'h2C2];
    start = 1'b1; mode = 1'b0; src = 10'h030; dst = 10'h2C0; len = 11'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);   // now just past edge 9: second write strobe up
    #1;
    check("rst_seq in_write2", {stb, we}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_seq outputs_zero", {busy, done, err, cyc, stb, we, sel, adr, dat_o}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_cnt = 0; cyc_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (cyc) cyc_cnt++;
    end
    check("rst_seq no_done", done_cnt, 0);
    check("rst_seq no_cyc", cyc_cnt, 0);
    check("rst_seq word0", mem[10'h2C0], 32'h11110001);
    check("rst_seq word2_untouched", mem[10'h2C2], old_w);

    // Randomized transfers with random responder wait states.
    for (int t = 0; t < 24; t++) begin
      delay_max = $urandom_range(3, 0);
      m = 1'($urandom_range(1, 0));
      s = 10'($urandom); d = 10'($urandom);
      n = $urandom_range(40, 1);
      f = $urandom;
      ee = (delay_max == 0) ? (m ? 3 * n - 1 : 6 * n - 1) : -1;
      es = (delay_max == 0) ? (m ? 2 * n : 4 * n) : -1;
      snapshot();
      xfer(m, s, d, 11'(n), f, -1, 6 * n * (delay_max + 2) + 20);
      apply_model(m, int'(s), int'(d), n, f);
      run_checks($sformatf("rand%0d", t), ee, 1'b0, es, 1'b1);
    end
    delay_max = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
